// File: rtl/masked_and_sequencer.sv
// Upstream sequencer for a D-share masked AND gadget: shares a/b using a free-running Galois LFSR,
// drives enable/done handshaking and captures the gadget's output shares. Option: MASKED_AND_UNMASK_DBG_EN.
module masked_and_sequencer #(
    parameter int                D        = 2,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int                MAX_WAIT = 7,
    localparam int               RAND_W   = D * (D - 1) / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              a,
    input  logic              b,
    output logic              busy,
    output logic [0:D-1]      ina,
    output logic [0:D-1]      inb,
    output logic [0:RAND_W-1] rin,
    output logic              and_enable,
    input  logic              and_done,
    input  logic [0:D-1]      and_out,
    output logic [0:D-1]      out_shares,
    output logic              valid,
    output logic              err,
    output logic              result_dbg
);

    localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic [0:D-1]        w_ina;
    logic [0:D-1]        w_inb;
    logic [0:RAND_W-1]   w_rin;
    logic                w_pa;
    logic                w_pb;
    logic                w_capture;
    logic                w_timeout;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // Random shares come straight from the current LFSR state; share 0 absorbs the plain bit.
    always_comb begin
        w_ina = '0;
        w_inb = '0;
        w_rin = '0;
        w_pa  = a;
        w_pb  = b;
        for (int i = 1; i < D; i++) begin
            w_ina[i] = r_lfsr[i-1];
            w_inb[i] = r_lfsr[D-2+i];
            w_pa     = w_pa ^ r_lfsr[i-1];
            w_pb     = w_pb ^ r_lfsr[D-2+i];
        end
        for (int j = 0; j < RAND_W; j++) begin
            w_rin[j] = r_lfsr[2*D-2+j];
        end
        w_ina[0] = w_pa;
        w_inb[0] = w_pb;
    end

    // The gadget's done flag is stale during the first RUN cycle, so it only counts from wcnt>=1.
    assign w_wcnt_nxt = r_wcnt + 1'b1;
    assign w_capture  = (r_state == S_RUN) && and_done && (r_wcnt != '0);
    assign w_timeout  = (r_state == S_RUN) && !w_capture && (w_wcnt_nxt == WCNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED_EFF;
            r_wcnt     <= '0;
            busy       <= 1'b0;
            ina        <= '0;
            inb        <= '0;
            rin        <= '0;
            and_enable <= 1'b0;
            out_shares <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
            valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        ina     <= w_ina;
                        inb     <= w_inb;
                        rin     <= w_rin;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    and_enable <= 1'b1;
                    r_wcnt     <= '0;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    r_wcnt <= w_wcnt_nxt;
                    if (w_capture) begin
                        out_shares <= and_out;
                        valid      <= 1'b1;
                        and_enable <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        err        <= 1'b1;
                        and_enable <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    and_enable <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MASKED_AND_UNMASK_DBG_EN
    logic r_result_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_dbg <= 1'b0;
        end else if (w_capture) begin
            r_result_dbg <= ^and_out;
        end
    end

    assign result_dbg = r_result_dbg;
`else
    // No recombination path exists, so only shares leave the block.
    assign result_dbg = 1'b0;
`endif

endmodule

// File: tb/tb_masked_and_sequencer.sv
// Directed bench for masked_and_sequencer with a behavioural D=2 masked AND gadget model.
module tb_masked_and_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       busy, and_enable, and_done, valid, err, result_dbg;
    logic [0:1] ina, inb, and_out, out_shares;
    logic [0:0] rin;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    masked_and_sequencer #(
        .D(2), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .MAX_WAIT(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy),
        .ina(ina), .inb(inb), .rin(rin), .and_enable(and_enable), .and_done(and_done),
        .and_out(and_out), .out_shares(out_shares), .valid(valid), .err(err),
        .result_dbg(result_dbg)
    );

    // Gadget model: loads shares while enable is low, raises done g_lat enabled edges later.
    // g_mode: 0 normal, 1 done stuck at 1, 2 done stuck at 0.
    int         g_mode = 0;
    int         g_lat = 1;
    int         g_cnt = 0;
    logic [0:1] g_ina = '0, g_inb = '0, g_out = '0;
    logic       g_rin = 1'b0, g_done = 1'b0;

    always @(posedge clk) begin
        if (!and_enable) begin
            g_ina  <= ina;
            g_inb  <= inb;
            g_rin  <= rin[0];
            g_cnt  <= 0;
            g_done <= 1'b0;
        end else if (!g_done) begin
            if (g_cnt == g_lat - 1) begin
                g_done   <= 1'b1;
                g_out[0] <= (g_ina[0] & g_inb[0]) ^ ((g_ina[0] & g_inb[1]) ^ g_rin);
                g_out[1] <= (g_ina[1] & g_inb[1]) ^ ((g_ina[1] & g_inb[0]) ^ g_rin);
            end
            g_cnt <= g_cnt + 1;
        end
    end

    assign and_done = (g_mode == 1) ? 1'b1 : (g_mode == 2) ? 1'b0 : g_done;
    assign and_out  = g_out;

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE; exp_ticks = edges from acceptance to capture/timeout edge.
    task automatic run_op(input logic ia, input logic ib, input int exp_ticks, input bit expect_to);
        logic [15:0] e;
        logic [0:1]  s_ina, s_inb, s_out;
        logic [0:0]  s_rin;
        logic        exp_dbg;
        int          n;
        a = ia;
        b = ib;
        start = 1'b1;
        e = m_lfsr;
        s_out = out_shares;
        tick();
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("prep_enable", and_enable, 0);
        chk("err_cleared", err, 0);
        chk("ina1_lfsr", ina[1], e[0]);
        chk("inb1_lfsr", inb[1], e[1]);
        chk("rin_lfsr", rin[0], e[2]);
        chk("ina_recomb", ina[0] ^ ina[1], ia);
        chk("inb_recomb", inb[0] ^ inb[1], ib);
        s_ina = ina;
        s_inb = inb;
        s_rin = rin;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("run_enable", and_enable, 1);
            chk("shares_held", {ina, inb, rin}, {s_ina, s_inb, s_rin});
        end while (busy && n < 15);
        chk("op_cycles", n, exp_ticks);
        chk("end_busy", busy, 0);
        chk("end_enable", and_enable, 0);
        if (!expect_to) begin
            chk("valid_pulse", valid, 1);
            chk("no_err", err, 0);
            chk("captured", out_shares, g_out);
            if (g_mode == 0) begin
                chk("result_xor", out_shares[0] ^ out_shares[1], ia & ib);
`ifdef MASKED_AND_UNMASK_DBG_EN
                exp_dbg = ia & ib;
`else
                exp_dbg = 1'b0;
`endif
                chk("result_dbg", result_dbg, exp_dbg);
            end
            tick();
            chk("valid_one_cycle", valid, 0);
        end else begin
            chk("timeout_err", err, 1);
            chk("timeout_no_valid", valid, 0);
            chk("timeout_out_kept", out_shares, s_out);
        end
    endtask

    initial begin
        logic [15:0] e;
        int          n;
        int          n_valid;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lfsr", dut.r_lfsr, 16'hACE1);
        chk("rst_outputs", {busy, ina, inb, rin, and_enable, out_shares, valid, err, result_dbg}, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_lfsr", dut.r_lfsr, 16'hACE1);
        tick();
        chk("lfsr_step1", dut.r_lfsr, 16'hE270);
        chk("idle_outputs", {busy, and_enable, valid, err}, 0);
        tick();
        chk("lfsr_step2", dut.r_lfsr, 16'h7138);

        g_mode = 0;
        g_lat = 1; run_op(1'b1, 1'b1, 3, 1'b0);
        g_lat = 2; run_op(1'b0, 1'b1, 4, 1'b0);
        g_lat = 3; run_op(1'b1, 1'b0, 5, 1'b0);
        g_lat = 1; run_op(1'b0, 1'b0, 3, 1'b0);
        g_lat = 2; run_op(1'b1, 1'b1, 4, 1'b0);

        g_mode = 1; g_lat = 3;
        run_op(1'b1, 1'b1, 3, 1'b0);

        g_mode = 2;
        run_op(1'b1, 1'b1, 8, 1'b1);

        g_mode = 0; g_lat = 1;
        run_op(1'b1, 1'b1, 3, 1'b0);

        // start held high: each valid cycle is IDLE, so the next op is accepted at once
        a = 1'b1;
        b = 1'b1;
        start = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 3; k++) begin
            e = m_lfsr;
            tick();
            chk("b2b_busy", busy, 1);
            chk("b2b_rin", rin[0], e[2]);
            chk("b2b_ina1", ina[1], e[0]);
            n = 0;
            do begin
                tick();
                n++;
            end while (!valid && n < 12);
            chk("b2b_cycles", n, 3);
            if (valid) n_valid++;
            chk("b2b_xor", out_shares[0] ^ out_shares[1], 1);
            if (k == 2) start = 1'b0;
        end
        chk("b2b_valids", n_valid, 3);
        tick();
        chk("b2b_idle", busy, 0);

        // reset during RUN
        g_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_run", and_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_enable", and_enable, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out", out_shares, 0);
        chk("rst_mid_lfsr", dut.r_lfsr, 16'hACE1);
        tick();
        rst_n = 1'b1;
        g_mode = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_no_valid", {valid, busy, err}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
